adder_pipe: RTL and testbench
=============================

# adder_pipe

Parametrised, pipelined arithmetic unit that succeeds the combinational 4-bit adder. It performs add, subtract, running accumulate and accumulator clear on WIDTH-bit operands. Results are ACC_W bits wide. Operands enter and results leave through valid/ready handshakes with full backpressure. It sits between an operand source (a driver or an upstream block) and a result consumer (a monitor or a downstream block).

## Interface
- WIDTH, 4: operand width in bits. Must be ≥ 1.
- ACC_W, 7: result and accumulator width in bits. Must be ≥ WIDTH+1.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  block accepts a beat this cycle. A beat transfers when in_valid && in_ready.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- op  in  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  out  1  a result is present.
- out_ready  in  1  consumer accepts the result. The result transfers when out_valid && out_ready.
- c  out  ACC_W  result.
- ovf  out  1  the result wrapped modulo 2^ACC_W. Only ACC can set it.

## Operation
- Two register stages:
  - S1 holds the captured beat and the computed result.
  - S2 is the output register driving c, ovf and out_valid.
- Arithmetic is computed combinationally at input acceptance and registered into S1:
  - ADD: c = zero-extend(a) + zero-extend(b). Never overflows because ACC_W ≥ WIDTH+1. ovf=0.
  - SUB: c = a − b as two's complement, sign-extended to ACC_W. For example, a=3, b=5 gives all-ones minus 1, i.e. −2. ovf=0.
  - ACC: acc_next = acc + zero-extend(a), modulo 2^ACC_W. c = acc_next. ovf = carry out of bit ACC_W−1. b is ignored.
  - CLR: acc_next = 0. c = 0. ovf=0. a and b are ignored.
- Accumulator `acc` (ACC_W bits):
  - Updates only on an accepted ACC or CLR beat.
  - Is unchanged by ADD and SUB.
  - Is never affected by output stalls.
- Results leave in strict acceptance order. No beat is dropped or duplicated.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no registered ready is required.
- When s2_adv is true:
  - S2 loads S1's contents.
  - s2_valid takes s1_valid.
- When s1_adv is true:
  - S1 loads the new beat.
  - s1_valid takes (in_valid && in_ready).

## Timing
- Reset values (asynchronous; applied immediately while rst=1):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - c=0, ovf=0, acc=0.
- in_ready is 1 whenever rst=0 and the pipe is not full.
- Latency is 2 cycles. A beat accepted at edge N appears on c/out_valid after edge N+1 and stays until the edge where out_ready=1.
- Throughput is 1 beat per cycle while out_ready=1.
- Full pipe: both stages valid and out_ready=0. In this state in_ready=0.
- Simultaneous events:
  - With the pipe full and out_ready=1, a new beat is accepted in the same cycle as the output transfer. No bubble is inserted.
- Stall behaviour: while out_valid=1 && out_ready=0, c and ovf hold stable.
- Accumulator ordering: a back-to-back ACC, ACC sequence uses the acc value updated by the first beat when computing the second. There is no hazard.
- Reset mid-operation: in-flight results are discarded and acc returns to 0. The first beat after reset deasserts sees acc=0.
- ovf is valid only while out_valid=1. It is 0 otherwise.

## Test plan
- Reset, then ADD with WIDTH=4, ACC_W=7, a=6, b=4, out_ready=1 -> c=10, ovf=0, out_valid high exactly 2 cycles after acceptance.
- SUB with a=3, b=5 -> c=7'h7E (−2). Then SUB with a=15, b=0 -> c=15.
- ACC stream of a=15 repeated 9 times, with ACC_W=7 -> c=15, 30, …, 120. Then 135 mod 128 = 7 with ovf=1. A following CLR -> c=0. A following ACC with a=1 -> c=1.
- Backpressure: push 4 ADD beats (1+1, 2+2, 3+3, 4+4) with out_ready=0 -> in_ready drops after 2 accepts and c holds at 2. Release out_ready -> results 2, 4, 6, 8 appear in order with no loss or duplicates.
- Simultaneous transfer: with the pipe full, in_valid=1 and out_ready=1 held for 10 cycles of random ADD/SUB -> one beat in and one beat out every cycle. Scoreboard matches a reference model.
- Assert rst during an ACC stream with acc=45 and 2 beats in flight -> out_valid=0 and c=0 immediately. After release, ACC with a=5 -> c=5.

Source files
------------

// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle for adder_pipe
interface adder_pipe_if #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] c;
    logic             ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - two-stage add/sub/accumulate unit with valid/ready backpressure
module adder_pipe #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave s_bus
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic [ACC_W-1:0] r_acc;
    logic             r_s1_valid;
    logic [ACC_W-1:0] r_s1_c;
    logic             r_s1_ovf;
    logic             r_s2_valid;
    logic [ACC_W-1:0] r_s2_c;
    logic             r_s2_ovf;

    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [ACC_W-1:0] w_acc_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_result;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;

    assign w_a_ext = {{(ACC_W-WIDTH){1'b0}}, s_bus.a};
    assign w_b_ext = {{(ACC_W-WIDTH){1'b0}}, s_bus.b};
    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, w_a_ext};

    assign w_s2_adv = !r_s2_valid || s_bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = s_bus.in_valid && s_bus.in_ready;

    // Modulo-2^ACC_W subtraction of zero-extended operands equals the sign-extended difference.
    always_comb begin
        w_result   = '0;
        w_ovf      = 1'b0;
        w_acc_next = r_acc;
        case (s_bus.op)
            OP_ADD: w_result = w_a_ext + w_b_ext;
            OP_SUB: w_result = w_a_ext - w_b_ext;
            OP_ACC: begin
                w_result   = w_acc_sum;
                w_ovf      = w_carry;
                w_acc_next = w_acc_sum;
            end
            OP_CLR: w_acc_next = '0;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_c     <= '0;
            r_s1_ovf   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_c     <= '0;
            r_s2_ovf   <= 1'b0;
        end else begin
            if (w_accept && s_bus.op[1]) begin
                r_acc <= w_acc_next;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_c     <= r_s1_c;
                r_s2_ovf   <= r_s1_ovf;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                r_s1_c     <= w_result;
                r_s1_ovf   <= w_ovf && w_accept;
            end
        end
    end

    assign s_bus.in_ready  = w_s1_adv && !rst;
    assign s_bus.out_valid = r_s2_valid;
    assign s_bus.c         = r_s2_c;
    assign s_bus.ovf       = r_s2_ovf && r_s2_valid;
endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed and scoreboarded checks for adder_pipe
module tb_adder_pipe;
    localparam int W  = 4;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(W), .ACC_W(AW)) bus ();

    adder_pipe #(.WIDTH(W), .ACC_W(AW)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int m_acc    = 0;
    int exp_c[$];
    bit exp_ovf[$];
    int got_c[$];
    bit got_ovf[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    endtask

    function automatic void model_push(input logic [1:0] op, input int a, input int b);
        int s;
        int r;
        bit o;
        o = 1'b0;
        case (op)
            2'd0: r = (a + b) % 128;
            2'd1: r = (a - b + 128) % 128;
            2'd2: begin
                s = m_acc + a;
                o = (s >= 128);
                m_acc = s % 128;
                r = m_acc;
            end
            default: begin
                m_acc = 0;
                r = 0;
            end
        endcase
        exp_c.push_back(r);
        exp_ovf.push_back(o);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_c.delete();
            exp_ovf.delete();
            m_acc = 0;
        end else begin
            if (bus.out_valid) begin
                if (exp_c.size() == 0) begin
                    chk("sb_unexpected_out", 1, 0);
                end else begin
                    chk("sb_c", int'(bus.c), exp_c[0]);
                    chk("sb_ovf", int'(bus.ovf), int'(exp_ovf[0]));
                    if (bus.out_ready) begin
                        got_c.push_back(int'(bus.c));
                        got_ovf.push_back(bus.ovf);
                        void'(exp_c.pop_front());
                        void'(exp_ovf.pop_front());
                    end
                end
            end else begin
                chk("ovf_idle", int'(bus.ovf), 0);
            end
            if (bus.in_valid && bus.in_ready) model_push(bus.op, int'(bus.a), int'(bus.b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input int a, input int b);
        bit ok;
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a[3:0];
        bus.b  = b[3:0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            if (ok) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #3;
            if (exp_c.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_timeout", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        int g0;
        logic [1:0] rop;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b0;

        #2;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_c", int'(bus.c), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rel_in_ready", int'(bus.in_ready), 1);

        // ADD 6+4 and two-cycle latency
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op = 2'd0; bus.a = 4'd6; bus.b = 4'd4;
        @(negedge clk);
        chk("t1_in_ready", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_lat1_valid", int'(bus.out_valid), 0);
        tick();
        chk("t1_lat2_valid", int'(bus.out_valid), 1);
        chk("t1_c", int'(bus.c), 10);
        chk("t1_ovf", int'(bus.ovf), 0);
        drain();

        // SUB
        base = got_c.size();
        send(2'd1, 3, 5);
        send(2'd1, 15, 0);
        idle();
        drain();
        chk("t2_sub_neg", got_c[base], 126);
        chk("t2_sub_pos", got_c[base+1], 15);

        // ACC stream with wrap, CLR, ACC
        base = got_c.size();
        for (int i = 0; i < 9; i++) send(2'd2, 15, 0);
        send(2'd3, 9, 9);
        send(2'd2, 1, 0);
        idle();
        drain();
        for (int i = 0; i < 8; i++) chk("t3_acc", got_c[base+i], 15 * (i + 1));
        chk("t3_acc_ovf0", int'(got_ovf[base+7]), 0);
        chk("t3_wrap_c", got_c[base+8], 7);
        chk("t3_wrap_ovf", int'(got_ovf[base+8]), 1);
        chk("t3_clr", got_c[base+9], 0);
        chk("t3_after_clr", got_c[base+10], 1);

        // Backpressure
        base = got_c.size();
        bus.out_ready = 1'b0;
        send(2'd0, 1, 1);
        send(2'd0, 2, 2);
        bus.in_valid = 1'b1;
        bus.op = 2'd0; bus.a = 4'd3; bus.b = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_in_ready_low", int'(bus.in_ready), 0);
            chk("t4_hold_valid", int'(bus.out_valid), 1);
            chk("t4_hold_c", int'(bus.c), 2);
            tick();
        end
        bus.out_ready = 1'b1;
        send(2'd0, 3, 3);
        send(2'd0, 4, 4);
        idle();
        drain();
        chk("t4_count", got_c.size() - base, 4);
        chk("t4_r0", got_c[base], 2);
        chk("t4_r1", got_c[base+1], 4);
        chk("t4_r2", got_c[base+2], 6);
        chk("t4_r3", got_c[base+3], 8);

        // Full pipe, simultaneous in/out
        bus.out_ready = 1'b0;
        send(2'd0, 1, 2);
        send(2'd1, 7, 9);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("t5_full_in_ready", int'(bus.in_ready), 0);
        tick();
        bus.out_ready = 1'b1;
        t0 = cyc;
        g0 = got_c.size();
        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 1));
            send(rop, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        chk("t5_throughput", cyc - t0, 10);
        chk("t5_out_count", got_c.size() - g0, 10);
        idle();
        drain();

        // Reset mid ACC stream
        send(2'd3, 0, 0);
        for (int i = 0; i < 3; i++) send(2'd2, 15, 0);
        idle();
        drain();
        bus.out_ready = 1'b0;
        send(2'd2, 1, 0);
        send(2'd2, 2, 0);
        idle();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", int'(bus.out_valid), 0);
        chk("t6_rst_c", int'(bus.c), 0);
        chk("t6_rst_ovf", int'(bus.ovf), 0);
        tick();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = got_c.size();
        send(2'd2, 5, 0);
        idle();
        drain();
        chk("t6_acc_after_rst", got_c[base], 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
